// File: rtl/picorv32_mem_pkg.sv
// Shared types and constants for the picorv32 native-bus memory responder.
package picorv32_mem_pkg;

  // Responder FSM: one access (core or WB) in flight at a time.
  typedef enum logic [1:0] {
    StIdle,
    StCoreWait,
    StCoreAck,
    StWbAck
  } state_e;

  localparam int unsigned CTRL_RUN_BIT = 0;
  localparam int unsigned CTRL_ERR_BIT = 1;
  localparam int unsigned WAIT_W       = 4;

endpackage

// File: rtl/picorv32_mem_sram.sv
// Single-port word RAM with byte enables and synchronous read-first output.
module picorv32_mem_sram #(
  parameter int unsigned AddrWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [2**AddrWidth];

  // Byte-masked write and registered read of the old word at the same address.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/picorv32_mem_responder.sv
// picorv32 native-bus memory responder with a Wishbone preload/control port.
module picorv32_mem_responder
  import picorv32_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] CORE_BASE   = 32'h0000_0000,
  parameter logic [31:0] WB_BASE     = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        core_resetn,
  output logic        err_o
);

  localparam int unsigned AW = ADDR_WIDTH;

  state_e              state_q;
  logic [WAIT_W-1:0]   cnt_q;
  logic                run_q, err_q;
  logic [AW-1:0]       core_idx_q;
  logic [31:0]         core_wdata_q;
  logic [3:0]          core_wstrb_q;
  logic                core_hit_q, core_we_q;
  logic                wb_ram_rd_q, wb_ctrl_rd_q;

  logic                wb_req, core_hit, wb_ram_hit, wb_ctrl_hit;
  logic [31:0]         wb_off;
  logic                sram_we;
  logic [3:0]          sram_be;
  logic [AW-1:0]       sram_addr;
  logic [31:0]         sram_wdata, sram_rdata;

  // Address decode for both ports; WB offsets are relative to WB_BASE.
  always_comb begin
    wb_req      = wbs_cyc_i & wbs_stb_i;
    core_hit    = mem_addr[31:AW+2] == CORE_BASE[31:AW+2];
    wb_off      = wbs_adr_i - WB_BASE;
    wb_ram_hit  = wb_off[31:AW+2] == '0;
    wb_ctrl_hit = wb_off[31:2] == 30'(2**AW);
  end

  // RAM port steering: live request fields in IDLE, captured core fields while waiting.
  always_comb begin
    sram_we    = 1'b0;
    sram_be    = 4'b0000;
    sram_addr  = core_idx_q;
    sram_wdata = core_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (wb_req) begin
          sram_addr  = wb_off[AW+1:2];
          sram_wdata = wbs_dat_i;
          sram_we    = wb_ram_hit & wbs_we_i;
          sram_be    = wbs_sel_i;
        end else if (mem_valid) begin
          sram_addr  = mem_addr[AW+1:2];
          sram_wdata = mem_wdata;
          // With no wait states the access completes on the accept edge.
          sram_we    = (WAIT_STATES == 0) & core_hit & (|mem_wstrb);
          sram_be    = mem_wstrb;
        end
      end
      StCoreWait: begin
        sram_we = (cnt_q == '0) & core_hit_q & core_we_q;
        sram_be = core_wstrb_q;
      end
      default: ;
    endcase
  end

  picorv32_mem_sram #(
    .AddrWidth(AW)
  ) u_sram (
    .clk_i  (wb_clk_i),
    .we_i   (sram_we),
    .be_i   (sram_be),
    .addr_i (sram_addr),
    .wdata_i(sram_wdata),
    .rdata_o(sram_rdata)
  );

  // Arbitration FSM, wait counter, request capture and CTRL register.
  always_ff @(posedge wb_clk_i or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      run_q        <= 1'b0;
      err_q        <= 1'b0;
      core_idx_q   <= '0;
      core_wdata_q <= '0;
      core_wstrb_q <= '0;
      core_hit_q   <= 1'b0;
      core_we_q    <= 1'b0;
      wb_ram_rd_q  <= 1'b0;
      wb_ctrl_rd_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (wb_req) begin
            state_q      <= StWbAck;
            wb_ram_rd_q  <= wb_ram_hit & ~wbs_we_i;
            wb_ctrl_rd_q <= wb_ctrl_hit & ~wbs_we_i;
            if (wb_ctrl_hit && wbs_we_i && wbs_sel_i[0]) begin
              run_q <= wbs_dat_i[CTRL_RUN_BIT];
              if (wbs_dat_i[CTRL_ERR_BIT]) err_q <= 1'b0;
            end
          end else if (mem_valid) begin
            core_idx_q   <= mem_addr[AW+1:2];
            core_wdata_q <= mem_wdata;
            core_wstrb_q <= mem_wstrb;
            core_hit_q   <= core_hit;
            core_we_q    <= |mem_wstrb;
            if (!core_hit) err_q <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_q <= StCoreAck;
            end else begin
              state_q <= StCoreWait;
              cnt_q   <= WAIT_W'(WAIT_STATES - 1);
            end
          end
        end
        StCoreWait: begin
          if (cnt_q == '0) state_q <= StCoreAck;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        StCoreAck: state_q <= StIdle;
        StWbAck:   state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  // Output muxing: data buses are zero outside their ready/ack cycle.
  always_comb begin
    mem_ready   = state_q == StCoreAck;
    wbs_ack_o   = state_q == StWbAck;
    mem_rdata   = (mem_ready && core_hit_q && !core_we_q) ? sram_rdata : 32'h0;
    wbs_dat_o   = 32'h0;
    if (wbs_ack_o && wb_ram_rd_q)  wbs_dat_o = sram_rdata;
    if (wbs_ack_o && wb_ctrl_rd_q) wbs_dat_o = {30'h0, err_q, run_q};
    core_resetn = run_q;
    err_o       = err_q;
  end

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Directed self-checking bench for picorv32_mem_responder (default parameters).
module tb_picorv32_mem_responder;

  localparam logic [31:0] WbBase = 32'h3000_0000;
  localparam logic [31:0] WbCtrl = 32'h3000_0400;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        core_resetn, err_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  picorv32_mem_responder dut (
    .wb_clk_i   (clk),
    .resetn     (resetn),
    .mem_valid  (mem_valid),
    .mem_instr  (mem_instr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .core_resetn(core_resetn),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = wdat; wbs_sel_i = sel;
    tick();
    check("wb_ack", 32'(wbs_ack_o), 32'd1);
    rdat = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    tick();
    check("wb_ack_one_cycle", 32'(wbs_ack_o), 32'd0);
  endtask

  // Holds mem_valid until mem_ready (bounded) and checks latency and read data.
  task automatic core_access(input string tag, input logic [31:0] adr, input logic [31:0] wdat,
                             input logic [3:0] strb, input int exp_lat,
                             input logic [31:0] exp_rdata);
    int lat = 0;
    mem_valid = 1'b1; mem_addr = adr; mem_wdata = wdat; mem_wstrb = strb;
    do begin
      tick();
      lat++;
    end while (!mem_ready && lat < 20);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, mem_rdata, exp_rdata);
    mem_valid = 1'b0;
    tick();
    check({tag, "_ready_pulse"}, 32'(mem_ready), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    int lat;
    resetn = 1'b1;
    mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
    #3 resetn = 1'b0;
    tick(); tick();
    #2 resetn = 1'b1;
    tick();

    // Reset asserted while a WB CTRL write is being acked.
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = WbCtrl; wbs_dat_i = 32'h1; wbs_sel_i = 4'hf;
    tick();
    check("pre_rst_ack", 32'(wbs_ack_o), 32'd1);
    check("pre_rst_run", 32'(core_resetn), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_wbdat", wbs_dat_o, 32'h0);
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_core_resetn", 32'(core_resetn), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    tick();
    #2 resetn = 1'b1;
    tick();
    check("post_rst_ack", 32'(wbs_ack_o), 32'd0);
    check("post_rst_ready", 32'(mem_ready), 32'd0);

    // WB preload and read-back.
    wb_access(1'b1, WbBase + 32'h10, 32'hDEAD_BEEF, 4'hf, d);
    check("wb_write_dat_zero", d, 32'h0);
    wb_access(1'b0, WbBase + 32'h10, 32'h0, 4'hf, d);
    check("wb_readback", d, 32'hDEAD_BEEF);
    wb_access(1'b1, WbBase + 32'h3FC, 32'h1234_5678, 4'hf, d);
    wb_access(1'b0, WbBase + 32'h3FC, 32'h0, 4'hf, d);
    check("wb_last_word", d, 32'h1234_5678);
    wb_access(1'b1, WbBase + 32'h3FC, 32'hFFFF_FFFF, 4'b1001, d);
    wb_access(1'b0, WbBase + 32'h3FC, 32'h0, 4'hf, d);
    check("wb_sel_merge", d, 32'hFF34_56FF);

    // Core read with one wait state, then byte write and read-back.
    mem_instr = 1'b1;
    core_access("core_rd", 32'h10, 32'h0, 4'h0, 2, 32'hDEAD_BEEF);
    mem_instr = 1'b0;
    core_access("core_wr", 32'h10, 32'h0000_AA00, 4'b0010, 2, 32'h0);
    core_access("core_rd2", 32'h10, 32'h0, 4'h0, 2, 32'hDEAD_AAEF);
    core_access("core_rd_top", 32'h3FC, 32'h0, 4'h0, 2, 32'hFF34_56FF);
    check("no_err_in_range", 32'(err_o), 32'd0);

    // Simultaneous WB read and core read: WB first, core 3 cycles after the ack.
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = WbBase + 32'h10; wbs_sel_i = 4'hf;
    mem_valid = 1'b1; mem_addr = 32'h10; mem_wstrb = 4'h0;
    tick();
    check("arb_wb_ack", 32'(wbs_ack_o), 32'd1);
    check("arb_wb_dat", wbs_dat_o, 32'hDEAD_AAEF);
    check("arb_core_wait", 32'(mem_ready), 32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!mem_ready && lat < 20);
    check("arb_core_lat", 32'(lat), 32'd3);
    check("arb_core_rdata", mem_rdata, 32'hDEAD_AAEF);
    check("arb_wbdat_idle", wbs_dat_o, 32'h0);
    mem_valid = 1'b0;
    tick();

    // Out-of-range core accesses: zero data, write dropped, sticky error.
    core_access("oor_rd", 32'h0000_1000, 32'h0, 4'h0, 2, 32'h0);
    check("oor_err", 32'(err_o), 32'd1);
    core_access("oor_wr", 32'h0000_1010, 32'h5555_5555, 4'hf, 2, 32'h0);
    core_access("oor_alias_rd", 32'h10, 32'h0, 4'h0, 2, 32'hDEAD_AAEF);
    check("err_sticky", 32'(err_o), 32'd1);
    wb_access(1'b0, WbCtrl, 32'h0, 4'hf, d);
    check("ctrl_rd_err", d, 32'h2);
    wb_access(1'b1, WbCtrl, 32'h3, 4'hf, d);
    check("ctrl_err_cleared", 32'(err_o), 32'd0);
    check("ctrl_run_set", 32'(core_resetn), 32'd1);
    wb_access(1'b0, WbCtrl, 32'h0, 4'hf, d);
    check("ctrl_rd_run", d, 32'h1);
    wb_access(1'b0, WbCtrl + 32'h4, 32'h0, 4'hf, d);
    check("wb_unmapped", d, 32'h0);
    check("unmapped_no_effect", 32'(core_resetn), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
